ssd1306_spi_receiver: RTL and testbench

SSD1306_SPI_RECEIVER -- requirements
Module: ssd1306_spi_receiver

---
 rtl/ssd1306_spi_receiver.sv | 232 +++++++++++++++++++++++
 tb/tb_ssd1306_spi_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver
//
// Write-only SSD1306-style SPI slave. SPI pins are synchronised into the clk_in domain.
// Mode-0 bytes are assembled from them and split by the dc pin into GDDRAM writes (dc=1)
// or parsed commands (dc=0).
//
// Optional feature: define SSD1306_RX_SYNC_DETECT_EN to enable frame-sync detection.
// The command sequence 0x40, 0xD3, 0x00 then pulses sync_det and rewinds the write pointer.
// Without the macro, sync_det is tied low.
//
// Ports
//   clk_in          system clock
//   reset_in        synchronous active-high reset
//   oled_csn        SPI chip select, active low (asynchronous)
//   oled_dc         1 = display data, 0 = command (asynchronous)
//   oled_clk        SPI clock, idles low, at most clk_in/4 (asynchronous)
//   oled_mosi       SPI data, MSB first (asynchronous)
//   byte_valid      one-cycle strobe per received byte
//   byte_data       received byte, valid with byte_valid
//   byte_dc         dc tag of the received byte, valid with byte_valid
//   pix_we          one-cycle GDDRAM write strobe
//   pix_addr        GDDRAM write address (page*128+column)
//   pix_data        GDDRAM write data (one 8-pixel vertical column)
//   display_on      1 after 0xAF, 0 after 0xAE
//   start_line      last display start line (from 0x40-0x7F)
//   display_offset  argument of the last 0xD3 command
//   frame_done      pulse with the write to address 1023
//   sync_det        pulse when the sync command sequence completes

module ssd1306_spi_receiver (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       oled_csn,
    input  logic       oled_dc,
    input  logic       oled_clk,
    input  logic       oled_mosi,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       pix_we,
    output logic [9:0] pix_addr,
    output logic [7:0] pix_data,
    output logic       display_on,
    output logic [5:0] start_line,
    output logic [5:0] display_offset,
    output logic       frame_done,
    output logic       sync_det
);

    typedef enum logic [1:0] {
        C_OP   = 2'd0,
        C_ARG1 = 2'd1,
        C_ARG2 = 2'd2
    } cmd_state_e;

`ifdef SSD1306_RX_SYNC_DETECT_EN
    typedef enum logic [1:0] {
        SyncNone  = 2'd0,
        SyncSaw40 = 2'd1,
        SyncSawD3 = 2'd2
    } sync_state_e;

    sync_state_e sync_state;
`endif

    // Two-flop synchronisers; index [1] is the synchronised value.
    logic [1:0] csn_sync;
    logic [1:0] dc_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       sclk_rise;

    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_dc;

    cmd_state_e cmd_state;
    logic [7:0] opcode;
    logic [9:0] wr_ptr;

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;

    function automatic logic is_one_arg(input logic [7:0] op);
        case (op)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: is_one_arg = 1'b1;
            default:                    is_one_arg = 1'b0;
        endcase
    endfunction

    function automatic logic is_two_arg(input logic [7:0] op);
        is_two_arg = (op == 8'h21) || (op == 8'h22);
    endfunction

    // SPI front end: synchronise, detect sclk rising edges, assemble bytes.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            csn_sync  <= '0;
            dc_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            rx_dc     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[0], oled_csn};
            dc_sync   <= {dc_sync[0], oled_dc};
            sclk_sync <= {sclk_sync[0], oled_clk};
            mosi_sync <= {mosi_sync[0], oled_mosi};
            sclk_prev <= sclk_sync[1];
            rx_valid  <= 1'b0;

            // Deselect both ignores sclk and drops any partial byte.
            if (csn_sync[1]) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_sync[1]};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {shift_reg, mosi_sync[1]};
                    rx_dc    <= dc_sync[1];
                end
            end
        end
    end

    // Byte dispatch: GDDRAM writes and the command parser, all outputs registered.
    // The parser survives csn deassertion so commands may span frames.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cmd_state      <= C_OP;
            opcode         <= '0;
            wr_ptr         <= '0;
            byte_valid     <= 1'b0;
            byte_data      <= '0;
            byte_dc        <= 1'b0;
            pix_we         <= 1'b0;
            pix_addr       <= '0;
            pix_data       <= '0;
            display_on     <= 1'b0;
            start_line     <= '0;
            display_offset <= '0;
            frame_done     <= 1'b0;
`ifdef SSD1306_RX_SYNC_DETECT_EN
            sync_state     <= SyncNone;
            sync_det       <= 1'b0;
`endif
        end else begin
            byte_valid <= rx_valid;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
`ifdef SSD1306_RX_SYNC_DETECT_EN
            sync_det   <= 1'b0;
`endif
            if (rx_valid) begin
                byte_data <= rx_byte;
                byte_dc   <= rx_dc;
                if (rx_dc) begin
                    // Data aborts any pending command arguments.
                    pix_we     <= 1'b1;
                    pix_addr   <= wr_ptr;
                    pix_data   <= rx_byte;
                    frame_done <= (wr_ptr == 10'd1023);
                    wr_ptr     <= wr_ptr + 10'd1;
                    cmd_state  <= C_OP;
`ifdef SSD1306_RX_SYNC_DETECT_EN
                    sync_state <= SyncNone;
`endif
                end else begin
                    unique case (cmd_state)
                        C_OP: begin
                            if (rx_byte[7:6] == 2'b01) begin
                                start_line <= rx_byte[5:0];
                            end else if (rx_byte == 8'hAE) begin
                                display_on <= 1'b0;
                            end else if (rx_byte == 8'hAF) begin
                                display_on <= 1'b1;
                            end else if (is_one_arg(rx_byte) || is_two_arg(rx_byte)) begin
                                opcode    <= rx_byte;
                                cmd_state <= C_ARG1;
                            end
`ifdef SSD1306_RX_SYNC_DETECT_EN
                            // A 0x40 always (re)starts a match.
                            if (rx_byte == 8'h40) begin
                                sync_state <= SyncSaw40;
                            end else if (rx_byte == 8'hD3 && sync_state == SyncSaw40) begin
                                sync_state <= SyncSawD3;
                            end else begin
                                sync_state <= SyncNone;
                            end
`endif
                        end
                        C_ARG1: begin
                            if (opcode == 8'hD3) begin
                                display_offset <= rx_byte[5:0];
                            end
                            cmd_state <= is_two_arg(opcode) ? C_ARG2 : C_OP;
`ifdef SSD1306_RX_SYNC_DETECT_EN
                            if (sync_state == SyncSawD3 && rx_byte == 8'h00) begin
                                sync_det <= 1'b1;
                                wr_ptr   <= '0;
                            end
                            sync_state <= SyncNone;
`endif
                        end
                        C_ARG2: begin
                            cmd_state <= C_OP;
`ifdef SSD1306_RX_SYNC_DETECT_EN
                            sync_state <= SyncNone;
`endif
                        end
                        default: begin
                            cmd_state <= C_OP;
                        end
                    endcase
                end
            end
        end
    end

`ifndef SSD1306_RX_SYNC_DETECT_EN
    assign sync_det = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver. A negedge monitor records strobes and
// their payloads; the main sequence drives SPI traffic and checks the records.
module tb_ssd1306_spi_receiver;

    localparam int unsigned Half = 3;  // SPI half period in clk_in cycles

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       oled_csn = 1'b1;
    logic       oled_dc = 1'b0;
    logic       oled_clk = 1'b0;
    logic       oled_mosi = 1'b0;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       pix_we;
    logic [9:0] pix_addr;
    logic [7:0] pix_data;
    logic       display_on;
    logic [5:0] start_line;
    logic [5:0] display_offset;
    logic       frame_done;
    logic       sync_det;

    ssd1306_spi_receiver dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .oled_csn       (oled_csn),
        .oled_dc        (oled_dc),
        .oled_clk       (oled_clk),
        .oled_mosi      (oled_mosi),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_dc        (byte_dc),
        .pix_we         (pix_we),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .display_on     (display_on),
        .start_line     (start_line),
        .display_offset (display_offset),
        .frame_done     (frame_done),
        .sync_det       (sync_det)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Monitor records
    int       bv_cnt = 0;
    int       we_cnt = 0;
    int       fd_cnt = 0;
    int       sync_cnt = 0;
    int       misalign = 0;
    int       frame_bad = 0;
    logic     chk_frame = 1'b0;
    logic [7:0] last_byte = '0;
    logic       last_dc = 1'b0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_pix = '0;
    logic [9:0] fd_addr = '0;

    always @(negedge clk_in) begin
        if (byte_valid) begin
            bv_cnt++;
            last_byte = byte_data;
            last_dc   = byte_dc;
        end
        if (pix_we) begin
            we_cnt++;
            last_addr = pix_addr;
            last_pix  = pix_data;
            if (!byte_valid || !byte_dc) misalign++;
            if (chk_frame && pix_data != pix_addr[7:0]) frame_bad++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_addr = pix_addr;
            if (!pix_we) misalign++;
        end
        if (sync_det) sync_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, input logic dc);
        oled_dc = dc;
        for (int i = 0; i < n; i++) begin
            oled_mosi = b[7-i];
            wait_cyc(Half);
            oled_clk = 1'b1;
            wait_cyc(Half);
            oled_clk = 1'b0;
        end
        wait_cyc(6);
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic dc);
        spi_bits(b, 8, dc);
    endtask

    task automatic csn_set(input logic v);
        oled_csn = v;
        wait_cyc(4);
    endtask

    task automatic do_reset();
        oled_csn = 1'b1;
        oled_clk = 1'b0;
        reset_in = 1'b1;
        wait_cyc(5);
        reset_in = 1'b0;
        wait_cyc(4);
    endtask

    int bv0;
    int we0;

    initial begin
        do_reset();
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_pix_we", pix_we, 1'b0);
        check("rst_display_on", display_on, 1'b0);
        check("rst_start_line", start_line, 6'd0);
        check("rst_display_offset", display_offset, 6'd0);
        check("rst_frame_sync", {frame_done, sync_det}, 2'b00);

        // Single data byte
        csn_set(1'b0);
        spi_byte(8'hA5, 1'b1);
        check("data_bv_cnt", bv_cnt, 1);
        check("data_byte", last_byte, 8'hA5);
        check("data_dc", last_dc, 1'b1);
        check("data_we_cnt", we_cnt, 1);
        check("data_addr", last_addr, 10'd0);
        check("data_pix", last_pix, 8'hA5);

        // Commands: display on, start line 0x12, display offset 0x25
        we0 = we_cnt;
        bv0 = bv_cnt;
        spi_byte(8'hAF, 1'b0);
        spi_byte(8'h52, 1'b0);
        spi_byte(8'hD3, 1'b0);
        spi_byte(8'h25, 1'b0);
        check("cmd_display_on", display_on, 1'b1);
        check("cmd_start_line", start_line, 6'h12);
        check("cmd_offset", display_offset, 6'h25);
        check("cmd_no_we", we_cnt - we0, 0);
        check("cmd_bv_cnt", bv_cnt - bv0, 4);
        check("cmd_dc", last_dc, 1'b0);

        // Partial byte discarded by csn rising
        bv0 = bv_cnt;
        spi_bits(8'hFF, 5, 1'b1);
        csn_set(1'b1);
        check("partial_no_bv", bv_cnt - bv0, 0);
        csn_set(1'b0);
        spi_byte(8'h3C, 1'b1);
        check("partial_bv_cnt", bv_cnt - bv0, 1);
        check("partial_byte", last_byte, 8'h3C);
        check("partial_addr", last_addr, 10'd1);

        // Data aborts a pending argument; parser back in C_OP
        we0 = we_cnt;
        spi_byte(8'h81, 1'b0);
        spi_byte(8'h77, 1'b1);
        check("abort_we", we_cnt - we0, 1);
        check("abort_pix", last_pix, 8'h77);
        check("abort_addr", last_addr, 10'd2);
        spi_byte(8'hAE, 1'b0);
        check("abort_display_off", display_on, 1'b0);

        // Two-argument command swallows exactly two bytes
        spi_byte(8'h21, 1'b0);
        spi_byte(8'hAF, 1'b0);
        spi_byte(8'hAF, 1'b0);
        check("twoarg_ignored", display_on, 1'b0);
        spi_byte(8'hAF, 1'b0);
        check("twoarg_back_op", display_on, 1'b1);

        // Reset clears parser-held state
        do_reset();
        check("rst2_start_line", start_line, 6'd0);
        check("rst2_offset", display_offset, 6'd0);
        check("rst2_display_on", display_on, 1'b0);

        // Full frame wrap
        csn_set(1'b0);
        we0 = we_cnt;
        chk_frame = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            spi_byte(i[7:0], 1'b1);
        end
        check("frame_we_cnt", we_cnt - we0, 1024);
        check("frame_done_cnt", fd_cnt, 1);
        check("frame_done_addr", fd_addr, 10'd1023);
        check("frame_data", frame_bad, 0);
        spi_byte(8'h00, 1'b1);
        chk_frame = 1'b0;
        check("frame_wrap_addr", last_addr, 10'd0);
        check("frame_done_once", fd_cnt, 1);

        // Sync sequence: 10 data bytes (addr 1..10), 0x40, csn high, 0xD3 0x00
        for (int i = 0; i < 10; i++) begin
            spi_byte(8'h10 + i[7:0], 1'b1);
        end
        check("presync_addr", last_addr, 10'd10);
        spi_byte(8'h40, 1'b0);
        csn_set(1'b1);
        csn_set(1'b0);
        spi_byte(8'hD3, 1'b0);
        spi_byte(8'h00, 1'b0);
        spi_byte(8'h99, 1'b1);
`ifdef SSD1306_RX_SYNC_DETECT_EN
        check("sync_cnt", sync_cnt, 1);
        check("sync_next_addr", last_addr, 10'd0);
`else
        check("sync_cnt", sync_cnt, 0);
        check("sync_next_addr", last_addr, 10'd11);
`endif
        check("sync_pix", last_pix, 8'h99);
        check("misalign", misalign, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
